// File: rtl/xy_scan_counter.sv
// Paired X/Y coordinate scanner for the VGA plot path: walks a rectangle, a row
// or a column between latched inclusive bounds, with start/busy/done handshake.
module xy_scan_counter #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = XW + YW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          enable,
  input  logic [1:0]    mode,
  input  logic [XW-1:0] x_start,
  input  logic [XW-1:0] x_end,
  input  logic [YW-1:0] y_start,
  input  logic [YW-1:0] y_end,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          plot,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] MODE_ROW = 2'b01;
  localparam logic [1:0] MODE_COL = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    mode_q, mode_d;
  logic [XW-1:0] xs_q, xs_d, xe_q, xe_d;
  logic [YW-1:0] ys_q, ys_d, ye_q, ye_d;
  logic          err_q, err_d;

  logic bounds_ok;
  logic last_pt;

  // Row mode ignores y_end and column mode ignores x_end, so only the active axes are checked.
  always_comb begin
    bounds_ok = 1'b0;
    case (mode)
      MODE_ROW: bounds_ok = (x_start <= x_end);
      MODE_COL: bounds_ok = (y_start <= y_end);
      default:  bounds_ok = (x_start <= x_end) && (y_start <= y_end);
    endcase
  end

  always_comb begin
    last_pt = 1'b0;
    case (mode_q)
      MODE_ROW: last_pt = (x_q == xe_q);
      MODE_COL: last_pt = (y_q == ye_q);
      default:  last_pt = (x_q == xe_q) && (y_q == ye_q);
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    count_d = count_q;
    mode_d  = mode_q;
    xs_d    = xs_q;
    xe_d    = xe_q;
    ys_d    = ys_q;
    ye_d    = ye_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (bounds_ok) begin
            mode_d  = mode;
            xs_d    = x_start;
            xe_d    = x_end;
            ys_d    = y_start;
            ye_d    = y_end;
            x_d     = x_start;
            y_d     = y_start;
            count_d = '0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (enable) begin
          count_d = count_q + CW'(1);
          // Coordinates only advance when not at the end point, so x_end at full scale never overflows.
          if (last_pt) begin
            state_d = DONE;
          end else begin
            case (mode_q)
              MODE_ROW: x_d = x_q + XW'(1);
              MODE_COL: y_d = y_q + YW'(1);
              default: begin
                if (x_q != xe_q) begin
                  x_d = x_q + XW'(1);
                end else begin
                  x_d = xs_q;
                  y_d = y_q + YW'(1);
                end
              end
            endcase
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      count_q <= '0;
      mode_q  <= '0;
      xs_q    <= '0;
      xe_q    <= '0;
      ys_q    <= '0;
      ye_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      ys_q    <= ys_d;
      ye_q    <= ye_d;
      err_q   <= err_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign count = count_q;
  assign plot  = (state_q == RUN) & enable;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign err   = err_q;

endmodule

// File: tb/tb_xy_scan_counter.sv
// Bench for xy_scan_counter: point-list model compared every cycle, plus
// hand-computed expectations for each directed scenario.
module tb_xy_scan_counter;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = XW + YW;
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  logic          clk = 1'b0;
  logic          reset, start, enable;
  logic [1:0]    mode;
  logic [XW-1:0] x_start, x_end;
  logic [YW-1:0] y_start, y_end;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          plot, busy, done, err;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  xy_scan_counter #(.XW(XW), .YW(YW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .enable(enable), .mode(mode),
    .x_start(x_start), .x_end(x_end), .y_start(y_start), .y_end(y_end),
    .x(x), .y(y), .plot(plot), .busy(busy), .done(done), .err(err), .count(count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: on accept, enumerate every point the scan must visit; each enabled RUN cycle consumes one.
  int   m_phase = P_IDLE;
  int   m_x = 0, m_y = 0, m_count = 0;
  logic m_err = 1'b0;
  int   qx[$], qy[$];
  int   px[$], py[$];

  always @(posedge clk) begin : model
    int xs, xe, ys, ye;
    bit ok;
    xs = int'(x_start); xe = int'(x_end); ys = int'(y_start); ye = int'(y_end);
    if (!reset) begin
      m_phase = P_IDLE; m_x = 0; m_y = 0; m_count = 0; m_err = 1'b0;
      qx.delete(); qy.delete();
    end else begin
      m_err = 1'b0;
      case (m_phase)
        P_IDLE: if (start) begin
          if (mode == 2'b01)      ok = (xs <= xe);
          else if (mode == 2'b10) ok = (ys <= ye);
          else                    ok = (xs <= xe) && (ys <= ye);
          if (ok) begin
            qx.delete(); qy.delete();
            if (mode == 2'b01) begin
              for (int i = xs; i <= xe; i++) begin qx.push_back(i); qy.push_back(ys); end
            end else if (mode == 2'b10) begin
              for (int j = ys; j <= ye; j++) begin qx.push_back(xs); qy.push_back(j); end
            end else begin
              for (int j = ys; j <= ye; j++)
                for (int i = xs; i <= xe; i++) begin qx.push_back(i); qy.push_back(j); end
            end
            m_x = xs; m_y = ys; m_count = 0; m_phase = P_RUN;
          end else begin
            m_err = 1'b1;
          end
        end
        P_RUN: if (enable) begin
          void'(qx.pop_front());
          void'(qy.pop_front());
          m_count++;
          if (qx.size() == 0) m_phase = P_DONE;
          else begin m_x = qx[0]; m_y = qy[0]; end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  always @(posedge clk) begin : compare
    logic exp_plot;
    #1;
    exp_plot = (m_phase == P_RUN) && enable;
    n_vec++;
    if (x !== m_x[XW-1:0] || y !== m_y[YW-1:0] || plot !== exp_plot ||
        busy !== (m_phase == P_RUN) || done !== (m_phase == P_DONE) ||
        err !== m_err || count !== m_count[CW-1:0]) begin
      n_err++;
      $display("FAIL cycle t=%0t: dut x=%0d y=%0d plot=%b busy=%b done=%b err=%b count=%0d; model x=%0d y=%0d plot=%b busy=%b done=%b err=%b count=%0d",
               $time, x, y, plot, busy, done, err, count, m_x, m_y, exp_plot,
               m_phase == P_RUN, m_phase == P_DONE, m_err, m_count);
    end
    if (plot === 1'b1) begin px.push_back(int'(x)); py.push_back(int'(y)); end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start_scan(input logic [1:0] m, input int xs, input int xe, input int ys, input int ye);
    @(negedge clk);
    mode = m; x_start = XW'(xs); x_end = XW'(xe); y_start = YW'(ys); y_end = YW'(ye);
    start = 1'b1;
    px.delete(); py.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the cycle index (first RUN cycle = 1) at which done is seen, then steps to IDLE.
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: no done within %0d cycles", cyc);
    end
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int ex[6];
    int ey[6];
    logic [7:0] bvec, dvec;
    reset = 1'b0; start = 1'b0; enable = 1'b1; mode = 2'b00;
    x_start = '0; x_end = '0; y_start = '0; y_end = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_count", int'(count), 0);
    reset = 1'b1;
    @(negedge clk);

    // 1: raster 3x2
    ex = '{0, 1, 2, 0, 1, 2};
    ey = '{0, 0, 0, 1, 1, 1};
    start_scan(2'b00, 0, 2, 0, 1);
    wait_done(1, cyc);
    check("raster_done_cycle", cyc, 7);
    check("raster_npoints", px.size(), 6);
    for (int i = 0; i < 6 && i < px.size(); i++) begin
      check($sformatf("raster_x%0d", i), px[i], ex[i]);
      check($sformatf("raster_y%0d", i), py[i], ey[i]);
    end
    check("raster_count", int'(count), 6);
    check("raster_busy_after", int'(busy), 0);

    // 2: same raster, paused three cycles after the second point
    start_scan(2'b00, 0, 2, 0, 1);
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    #1;
    check("pause_plot", int'(plot), 0);
    check("pause_x", int'(x), 2);
    check("pause_y", int'(y), 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    enable = 1'b1;
    wait_done(6, cyc);
    check("pause_done_cycle", cyc, 10);
    check("pause_count", int'(count), 6);
    check("pause_npoints", px.size(), 6);

    // 3: row near the right edge, column near the bottom, row ending at full scale
    start_scan(2'b01, 155, 159, 119, 0);
    wait_done(1, cyc);
    check("row_done_cycle", cyc, 6);
    check("row_npoints", px.size(), 5);
    for (int i = 0; i < 5 && i < px.size(); i++) begin
      check($sformatf("row_x%0d", i), px[i], 155 + i);
      check($sformatf("row_y%0d", i), py[i], 119);
    end
    start_scan(2'b10, 7, 0, 117, 119);
    wait_done(1, cyc);
    check("col_npoints", px.size(), 3);
    for (int i = 0; i < 3 && i < px.size(); i++) begin
      check($sformatf("col_x%0d", i), px[i], 7);
      check($sformatf("col_y%0d", i), py[i], 117 + i);
    end
    check("col_count", int'(count), 3);
    start_scan(2'b01, 253, 255, 5, 5);
    wait_done(1, cyc);
    check("fullscale_npoints", px.size(), 3);
    check("fullscale_x_hold", int'(x), 255);

    // 4: rejected bounds, then a single point
    start_scan(2'b00, 10, 5, 0, 0);
    check("bad_err", int'(err), 1);
    check("bad_busy", int'(busy), 0);
    check("bad_count_kept", int'(count), 3);
    @(negedge clk);
    check("bad_err_cleared", int'(err), 0);
    start_scan(2'b00, 3, 3, 4, 4);
    wait_done(1, cyc);
    check("single_done_cycle", cyc, 2);
    check("single_npoints", px.size(), 1);
    check("single_x", px.size() > 0 ? px[0] : -1, 3);
    check("single_y", py.size() > 0 ? py[0] : -1, 4);

    // 5: start held high through two back-to-back 2-point scans
    @(negedge clk);
    mode = 2'b00; x_start = 8'd0; x_end = 8'd1; y_start = 7'd0; y_end = 7'd0;
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bvec[i] = busy;
      dvec[i] = done;
      if (i == 7) start = 1'b0;
    end
    check("held_busy_pattern", int'(bvec), 8'b0011_0011);
    check("held_done_pattern", int'(dvec), 8'b0100_0100);
    @(negedge clk);
    check("held_no_restart", int'(busy), 0);

    // 6: reset on the second RUN cycle, then a normal scan
    start_scan(2'b00, 0, 2, 0, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    start_scan(2'b00, 1, 2, 1, 1);
    wait_done(1, cyc);
    check("after_rst_done_cycle", cyc, 3);
    check("after_rst_count", int'(count), 2);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/xy_scan_counter.md
Name: xy_scan_counter

Overview:
Parametrised 2-D coordinate generator for the VGA plotting path. Replaces the single-axis wrap counter with a paired X/Y scanner. The scanner walks a programmable rectangle, a single row, or a single column. It has a start/busy/done handshake, pause via enable, bounds checking and a plotted-point tally. It drives the x, y and plot inputs of the VGA adapter.

Parameters:
XW, 8, width of X coordinate (160-pixel screen)
YW, 7, width of Y coordinate (120-line screen)
CW, XW+YW, width of point tally

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-low reset
start  input  1  request new scan; sampled only in IDLE
enable  input  1  advance permission; 0 pauses an active scan
mode  input  2  00 raster, 01 single row, 10 single column, 11 treated as raster
x_start  input  XW  first X (inclusive)
x_end  input  XW  last X (inclusive)
y_start  input  YW  first Y (inclusive)
y_end  input  YW  last Y (inclusive)
x  output  XW  current X coordinate (registered)
y  output  YW  current Y coordinate (registered)
plot  output  1  current (x,y) valid this cycle; equals (state==RUN) & enable
busy  output  1  high in RUN
done  output  1  one-cycle pulse after last point
err  output  1  one-cycle pulse on rejected start
count  output  CW  points plotted since last accepted start

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; x=0, y=0, count=0, busy=0, done=0, err=0; latched bounds/mode=0. Overrides everything, including mid-scan.
- FSM states: IDLE, RUN, DONE.
- IDLE + start=1, bounds valid: latch mode, x_start, x_end, y_start, y_end. Load x=x_start, y=y_start, count=0. Next state RUN. Inputs may change after this edge.
- Bounds valid means x_start<=x_end and y_start<=y_end, compared unsigned. Row mode ignores y_end; column mode ignores x_end.
- IDLE + start=1, bounds invalid: err=1 for exactly the next cycle. Stay IDLE; x, y, count unchanged.
- RUN, enable=0: plot=0; x, y, count hold.
- RUN, enable=1: plot=1; count increments at the clock edge. Coordinates then advance:
  - raster: if x!=x_end_l then x+1. Otherwise x=x_start_l and y+1.
  - row: x+1; y fixed at y_start_l.
  - column: y+1; x fixed at x_start_l.
- Last point:
  - raster: x==x_end_l && y==y_end_l.
  - row: x==x_end_l.
  - column: y==y_end_l.
  - On the edge that emits the last point: next state DONE; x, y hold at the last coordinates.
- Arithmetic: X never exceeds x_end_l, and Y never exceeds y_end_l.
  - Wrap is to the latched start, never to 0, and never by modulo 2^XW.
  - x_end = 2^XW-1 is legal and must not overflow.
- DONE: done=1, busy=0, plot=0 for one cycle; next state IDLE. x, y, count hold until the next accepted start.
- start in RUN or DONE is ignored; no queueing.
- Latency: start edge -> first plot in the following cycle (enable=1). Total RUN cycles = points + paused cycles.
- Points: raster (xe-xs+1)*(ye-ys+1); row (xe-xs+1); column (ye-ys+1).
- Single-point case (start==end on the active axes): one plot cycle, then DONE.
- Reset mid-RUN: scan abandoned; no done pulse.

Test Plan:
1. Raster, xs=0 xe=2 ys=0 ye=1, enable=1 -> plot for 6 cycles at (0,0)(1,0)(2,0)(0,1)(1,1)(2,1). Then done for 1 cycle, count=6, busy low after.
2. Raster run from case 1 with enable low for 3 cycles after the 2nd point -> x,y hold at (2,0) with plot=0. Sequence then resumes unchanged, done arrives 3 cycles later, count=6.
3. Row mode xs=155 xe=159 ys=119, and column mode xs=7 ys=117 ye=119:
   - Row -> x 155..159, y stays 119, 5 plots, no wrap to 160.
   - Column -> y 117..119, x stays 7, 3 plots.
4. Bounds and single point:
   - xs=10 xe=5 -> err pulse 1 cycle, busy stays 0, x,y,count unchanged.
   - xs=xe=3, ys=ye=4 -> exactly 1 plot at (3,4), then done.
5. start=1 held through a whole raster scan -> no restart while busy. A new scan begins only on the IDLE cycle after done.
6. reset=0 on 2nd RUN cycle -> next cycle x=0, y=0, count=0, busy=0, no done pulse. A subsequent start is accepted normally.
